countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter TICKS_PER_SEC, default 100, is the number of clk cycles per counted second (minimum 2).
REQ-002 Port clk, input, 1, the single system clock; all state updates on the rising edge.
REQ-003 Port resetn, input, 1, asynchronous active-low reset.
REQ-004 Port clearn, input, 1, clear button, active-low, synchronous, already debounced.
REQ-005 Port key_valid, input, 1, one-cycle strobe qualifying key_digit.
REQ-006 Port key_digit, input, 4, keypad digit in BCD.
REQ-007 Port magnetron_on, input, 1, level from the magnetron latch; high means cooking.
REQ-008 Port min_tens, min_ones, sec_tens, sec_ones, output, 4 each, current count in BCD, mm:ss.
REQ-009 Port timer_done, output, 1, registered, high whenever the count is 0000; this is the level consumed by the on/off logic.
REQ-010 Port done_pulse, output, 1, registered, one-cycle pulse when a run counts down to 0000.
REQ-011 Port running, output, 1, registered, high in state RUN.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE (count 0000), SET (count nonzero, not counting), RUN, DONE.
REQ-013 Key entry SHALL shift left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_digit; old min_tens is discarded.
REQ-014 Key entry SHALL be accepted only in IDLE and SET; key_valid in RUN or DONE is ignored.
REQ-015 A key_digit greater than 9 SHALL be ignored with no state or count change.
REQ-016 IDLE->SET when an accepted key makes the count nonzero; entering digit 0 in IDLE leaves it in IDLE.
REQ-017 SET->RUN when magnetron_on=1; IDLE ignores magnetron_on.
REQ-018 In RUN, an internal prescaler SHALL count 0..TICKS_PER_SEC-1; on each wrap from TICKS_PER_SEC-1 to 0 the count decrements once.
REQ-019 BCD decrement: sec_ones>0 -> sec_ones-1; else sec_ones=9 and, if sec_tens>0, sec_tens-1; else sec_tens=5 and the minutes decrement the same way (min_ones 0 -> 9 with min_tens-1).
REQ-020 Entered seconds above 59 (e.g. 0:90) SHALL be legal and count down by plain BCD (0:90 -> 0:89).
REQ-021 A decrement reaching 0000 SHALL move RUN->DONE; DONE lasts exactly one cycle then goes to IDLE; done_pulse=1 only while in DONE.
REQ-022 In RUN with magnetron_on=0 (pause) the FSM SHALL go to SET, holding the count and the prescaler value; resuming continues from the held prescaler value.
REQ-023 The prescaler SHALL clear to 0 on entry to IDLE and on every accepted key entry.
REQ-024 clearn=0 in any state SHALL zero the count and prescaler and force IDLE next cycle, with no done_pulse.
REQ-025 Priority SHALL be: resetn > clearn > decrement or key entry > magnetron_on transition.
REQ-026 If a prescaler wrap and magnetron_on=0 occur in the same RUN cycle, the decrement applies; next state is DONE if the result is 0000, else SET.
REQ-027 timer_done SHALL equal (next count == 0000), registered, so it updates in the same cycle as the digits.
REQ-028 The decrement SHALL never be performed on count 0000.

Reset
REQ-029 While resetn=0, all outputs and state SHALL be: state IDLE, all digits 0, prescaler 0, timer_done=1, done_pulse=0, running=0.
REQ-030 Reset deassertion SHALL take effect synchronously on the next clk edge.
REQ-031 Reset asserted during RUN SHALL abort the run with no done_pulse.

Verification
REQ-032 Key sequence 1,3,0 from reset -> digits 0,1,3,0 (1:30), state SET, timer_done=0.
REQ-033 Load 0:02, hold magnetron_on=1 -> 0:01 after TICKS_PER_SEC cycles, 0:00 after 2*TICKS_PER_SEC cycles, one-cycle done_pulse, timer_done=1, running=0.
REQ-034 Load 1:00, run one second -> 0:59; load 0:90, run one second -> 0:89.
REQ-035 Run 0:05, drop magnetron_on at prescaler value 40, re-assert -> the next decrement occurs 60 cycles later (TICKS_PER_SEC=100).
REQ-036 clearn=0 with key_valid=1 in the same cycle in SET -> count 0000, IDLE, digit not entered; clearn=0 in RUN -> IDLE, no done_pulse.
REQ-037 Key digit 0xA in IDLE -> no change; five keys 1,2,3,4,5 -> 23:45; resetn=0 mid-RUN -> REQ-029 values immediately, before any clk edge.

Source files
------------

// File: rtl/countdown_timer.sv
// ----------------------------------------------------------------------------
// countdown_timer
//
// Microwave-style mm:ss countdown timer. Digits are entered on a keypad and
// shift in from the right. Counting starts while the magnetron latch reports
// cooking. When the run reaches 00:00, a one-cycle done pulse is raised.
//
// Parameters
//   TICKS_PER_SEC : clk cycles per counted second (minimum 2)
//
// Ports
//   clk          in   system clock, rising edge
//   resetn       in   asynchronous active-low reset
//   clearn       in   synchronous active-low clear button (already debounced)
//   key_valid    in   one-cycle strobe qualifying key_digit
//   key_digit    in   [3:0] keypad digit, BCD; values above 9 are ignored
//   magnetron_on in   magnetron latch level, high while cooking
//   min_tens     out  [3:0] minutes tens digit
//   min_ones     out  [3:0] minutes ones digit
//   sec_tens     out  [3:0] seconds tens digit
//   sec_ones     out  [3:0] seconds ones digit
//   timer_done   out  registered, high whenever the count is 00:00
//   done_pulse   out  registered, one cycle when a run reaches 00:00
//   running      out  registered, high while counting (state RUN)
// ----------------------------------------------------------------------------
module countdown_timer #(
   parameter int TICKS_PER_SEC = 100
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       clearn,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   input  logic       magnetron_on,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       timer_done,
   output logic       done_pulse,
   output logic       running
);

   localparam int PW = $clog2(TICKS_PER_SEC);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,   // count is 00:00
      SET  = 2'd1,   // count nonzero, not counting
      RUN  = 2'd2,   // counting down
      DONE = 2'd3    // single cycle after reaching 00:00
   } state_t;

   state_t        state_reg, state_next;
   logic [15:0]   count_reg, count_next;     // {min_tens, min_ones, sec_tens, sec_ones}
   logic [PW-1:0] presc_reg, presc_next;
   logic          timer_done_reg;
   logic          done_pulse_reg;
   logic          running_reg;

   logic          key_ok;
   logic [15:0]   shifted_count;
   logic [15:0]   dec_count;
   logic          presc_wrap;

   // -------------------------------------------------------------------------
   // Plain BCD decrement of mm:ss. Seconds roll 0 -> 59 and minutes roll
   // 0 -> 9 with a borrow from the tens. Seconds above 59 that were keyed in
   // simply count down digit by digit (0:90 -> 0:89).
   // -------------------------------------------------------------------------
   function automatic logic [15:0] bcd_dec(input logic [15:0] c);
      logic [3:0] mt, mo, st, so;
      mt = c[15:12];
      mo = c[11:8];
      st = c[7:4];
      so = c[3:0];
      if (so != 4'd0) begin
         so = so - 4'd1;
      end else begin
         so = 4'd9;
         if (st != 4'd0) begin
            st = st - 4'd1;
         end else begin
            st = 4'd5;
            if (mo != 4'd0) begin
               mo = mo - 4'd1;
            end else begin
               mo = 4'd9;
               if (mt != 4'd0) begin
                  mt = mt - 4'd1;
               end
            end
         end
      end
      return {mt, mo, st, so};
   endfunction

   assign key_ok        = key_valid && (key_digit <= 4'd9);
   assign shifted_count = {count_reg[11:0], key_digit};   // old min_tens falls off
   assign dec_count     = bcd_dec(count_reg);
   assign presc_wrap    = (presc_reg == PRESC_MAX);

   // -------------------------------------------------------------------------
   // Next-state, count and prescaler logic.
   // Priority: clear, then decrement or key entry, then the magnetron level.
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      presc_next = presc_reg;

      if (!clearn) begin
         state_next = IDLE;
         count_next = '0;
         presc_next = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (key_ok) begin
                  count_next = shifted_count;
                  presc_next = '0;
                  if (shifted_count != 16'd0) begin
                     state_next = SET;
                  end
               end
            end

            SET: begin
               // A key takes precedence over starting the run. Shifting can
               // drop the only nonzero digit (10:00 then 0), which empties the
               // count and returns the FSM to IDLE.
               if (key_ok) begin
                  count_next = shifted_count;
                  presc_next = '0;
                  if (shifted_count == 16'd0) begin
                     state_next = IDLE;
                  end
               end else if (magnetron_on) begin
                  state_next = RUN;
               end
            end

            RUN: begin
               if (presc_wrap) begin
                  presc_next = '0;
                  // A RUN count is always nonzero. The guard keeps a zero
                  // count from ever wrapping to 99:59.
                  if (count_reg != 16'd0) begin
                     count_next = dec_count;
                  end
                  if (count_reg == 16'd0 || dec_count == 16'd0) begin
                     state_next = DONE;
                  end else if (!magnetron_on) begin
                     state_next = SET;
                  end
               end else if (!magnetron_on) begin
                  // Pause: the prescaler holds so that resuming finishes the
                  // partially elapsed second.
                  state_next = SET;
               end else begin
                  presc_next = presc_reg + PW'(1);
               end
            end

            DONE: begin
               state_next = IDLE;
               presc_next = '0;
            end

            default: begin
               state_next = IDLE;
               count_next = '0;
               presc_next = '0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // State and registered outputs. The flags are computed from next-cycle
   // values so they change on the same edge as the digits and the state.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg      <= IDLE;
         count_reg      <= '0;
         presc_reg      <= '0;
         timer_done_reg <= 1'b1;
         done_pulse_reg <= 1'b0;
         running_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         count_reg      <= count_next;
         presc_reg      <= presc_next;
         timer_done_reg <= (count_next == 16'd0);
         done_pulse_reg <= (state_next == DONE);
         running_reg    <= (state_next == RUN);
      end
   end

   assign min_tens   = count_reg[15:12];
   assign min_ones   = count_reg[11:8];
   assign sec_tens   = count_reg[7:4];
   assign sec_ones   = count_reg[3:0];
   assign timer_done = timer_done_reg;
   assign done_pulse = done_pulse_reg;
   assign running    = running_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// ----------------------------------------------------------------------------
// tb_countdown_timer
//
// Directed bench for countdown_timer with TICKS_PER_SEC = 100. Inputs are
// driven 1 ns after a rising edge, and outputs are sampled at that same point.
// Expected values are written out by hand for each step.
// ----------------------------------------------------------------------------
module tb_countdown_timer;

   localparam int TPS = 100;

   logic       clk = 1'b0;
   logic       resetn;
   logic       clearn;
   logic       key_valid;
   logic [3:0] key_digit;
   logic       magnetron_on;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       timer_done, done_pulse, running;

   int err_cnt = 0;
   int chk_cnt = 0;

   countdown_timer #(.TICKS_PER_SEC(TPS)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .clearn       (clearn),
      .key_valid    (key_valid),
      .key_digit    (key_digit),
      .magnetron_on (magnetron_on),
      .min_tens     (min_tens),
      .min_ones     (min_ones),
      .sec_tens     (sec_tens),
      .sec_ones     (sec_ones),
      .timer_done   (timer_done),
      .done_pulse   (done_pulse),
      .running      (running)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %-20s got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %-20s value=%0h", tag, got);
      end
   endtask

   function automatic logic [31:0] cnt();
      return {16'd0, min_tens, min_ones, sec_tens, sec_ones};
   endfunction

   // Advance n rising edges, then settle 1 ns past the last edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] d);
      key_valid = 1'b1;
      key_digit = d;
      step(1);
      key_valid = 1'b0;
      key_digit = 4'd0;
   endtask

   task automatic do_clear();
      clearn = 1'b0;
      step(1);
      clearn = 1'b1;
   endtask

   initial begin
      resetn       = 1'b1;
      clearn       = 1'b1;
      key_valid    = 1'b0;
      key_digit    = 4'd0;
      magnetron_on = 1'b0;

      // Reset is asserted before the first clock edge.
      #2 resetn = 1'b0;
      #1;
      chk("rst_count", cnt(), 32'h0000);
      chk("rst_timer_done", {31'd0, timer_done}, 32'd1);
      chk("rst_done_pulse", {31'd0, done_pulse}, 32'd0);
      chk("rst_running", {31'd0, running}, 32'd0);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      step(1);
      chk("post_rst_count", cnt(), 32'h0000);

      // Keys 1,3,0 give 1:30 in SET.
      press(4'd1);
      press(4'd3);
      press(4'd0);
      chk("key130_count", cnt(), 32'h0130);
      chk("key130_timer_done", {31'd0, timer_done}, 32'd0);
      chk("key130_running", {31'd0, running}, 32'd0);

      // Out-of-range key while in SET
      press(4'hB);
      chk("set_badkey_count", cnt(), 32'h0130);

      // Clear together with a key while in SET: the digit is not entered.
      clearn    = 1'b0;
      key_valid = 1'b1;
      key_digit = 4'd7;
      step(1);
      clearn    = 1'b1;
      key_valid = 1'b0;
      chk("clr_key_count", cnt(), 32'h0000);
      chk("clr_key_timer_done", {31'd0, timer_done}, 32'd1);
      chk("clr_key_running", {31'd0, running}, 32'd0);
      magnetron_on = 1'b1;                        // IDLE ignores magnetron
      step(2);
      chk("idle_mag_running", {31'd0, running}, 32'd0);
      magnetron_on = 1'b0;

      // Key 0xA and key 0 in IDLE, then five keys produce 23:45.
      press(4'hA);
      chk("idle_badkey_count", cnt(), 32'h0000);
      chk("idle_badkey_done", {31'd0, timer_done}, 32'd1);
      press(4'd0);
      magnetron_on = 1'b1;
      step(1);
      chk("idle_zero_running", {31'd0, running}, 32'd0);
      magnetron_on = 1'b0;
      press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
      chk("five_keys_count", cnt(), 32'h2345);

      // 0:02 countdown to done
      do_clear();
      press(4'd2);
      magnetron_on = 1'b1;
      step(1);                                    // SET -> RUN, prescaler 0
      chk("run02_running", {31'd0, running}, 32'd1);
      step(TPS - 1);
      chk("run02_before_tick", cnt(), 32'h0002);
      step(1);
      chk("run02_one_sec", cnt(), 32'h0001);
      chk("run02_one_pulse", {31'd0, done_pulse}, 32'd0);
      step(TPS - 1);
      chk("run02_pre_zero", cnt(), 32'h0001);
      chk("run02_pre_done_flag", {31'd0, timer_done}, 32'd0);
      step(1);
      chk("run02_zero_count", cnt(), 32'h0000);
      chk("run02_done_pulse", {31'd0, done_pulse}, 32'd1);
      chk("run02_timer_done", {31'd0, timer_done}, 32'd1);
      chk("run02_running_off", {31'd0, running}, 32'd0);
      step(1);
      chk("run02_pulse_end", {31'd0, done_pulse}, 32'd0);
      step(3);
      chk("run02_idle_running", {31'd0, running}, 32'd0);
      chk("run02_idle_count", cnt(), 32'h0000);
      magnetron_on = 1'b0;

      // 1:00 counts down to 0:59.
      do_clear();
      press(4'd1); press(4'd0); press(4'd0);
      magnetron_on = 1'b1;
      step(1 + TPS);
      chk("run100_to_059", cnt(), 32'h0059);
      magnetron_on = 1'b0;
      do_clear();

      // 0:90 counts down to 0:89.
      press(4'd9); press(4'd0);
      magnetron_on = 1'b1;
      step(1 + TPS);
      chk("run090_to_089", cnt(), 32'h0089);
      magnetron_on = 1'b0;
      do_clear();

      // Pause at prescaler 40. After resuming, the tick is 60 RUN edges later.
      press(4'd5);
      magnetron_on = 1'b1;
      step(1);                                    // RUN, prescaler 0
      step(40);                                   // prescaler 40
      magnetron_on = 1'b0;
      step(1);                                    // RUN -> SET, prescaler held
      chk("pause_running", {31'd0, running}, 32'd0);
      step(5);
      chk("pause_hold_count", cnt(), 32'h0005);
      magnetron_on = 1'b1;
      step(1);                                    // SET -> RUN
      chk("resume_running", {31'd0, running}, 32'd1);
      step(59);
      chk("resume_before_tick", cnt(), 32'h0005);
      step(1);
      chk("resume_tick", cnt(), 32'h0004);

      // A prescaler wrap and a magnetron drop in the same cycle decrement,
      // then go to SET.
      step(TPS - 1);
      magnetron_on = 1'b0;
      step(1);
      chk("wrap_pause_count", cnt(), 32'h0003);
      chk("wrap_pause_running", {31'd0, running}, 32'd0);

      // Key while running is ignored.
      magnetron_on = 1'b1;
      step(1);
      press(4'd7);
      chk("run_key_ignored", cnt(), 32'h0003);

      // Clear during RUN
      step(10);
      clearn = 1'b0;
      step(1);
      clearn = 1'b1;
      chk("clr_run_count", cnt(), 32'h0000);
      chk("clr_run_running", {31'd0, running}, 32'd0);
      chk("clr_run_pulse", {31'd0, done_pulse}, 32'd0);
      chk("clr_run_timer_done", {31'd0, timer_done}, 32'd1);
      step(1);
      chk("clr_run_pulse_after", {31'd0, done_pulse}, 32'd0);

      // Reset during RUN takes effect before any clock edge.
      press(4'd8);
      step(20);
      chk("pre_rst_running", {31'd0, running}, 32'd1);
      resetn = 1'b0;
      #1;
      chk("mid_rst_count", cnt(), 32'h0000);
      chk("mid_rst_running", {31'd0, running}, 32'd0);
      chk("mid_rst_timer_done", {31'd0, timer_done}, 32'd1);
      chk("mid_rst_pulse", {31'd0, done_pulse}, 32'd0);
      step(2);
      resetn = 1'b1;
      magnetron_on = 1'b0;
      step(2);
      chk("post_mid_rst_pulse", {31'd0, done_pulse}, 32'd0);
      chk("post_mid_rst_count", cnt(), 32'h0000);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
